// File: rtl/bp_pkg.sv
// Branch-predictor helpers: saturating counter step and metadata field offsets.
package bp_pkg;

   // Counters up to this width are supported by the shared step function.
   localparam int unsigned SAT_CTR_MAX_W = 8;
   typedef logic [SAT_CTR_MAX_W-1:0] sat_ctr_t;

   // Metadata layout, LSB first: lpred, gpred, lidx, gidx, ghr_ckpt.
   localparam int unsigned META_LPRED_BIT = 0;
   localparam int unsigned META_GPRED_BIT = 1;
   localparam int unsigned META_LIDX_LSB  = 2;

   function automatic int unsigned meta_gidx_lsb(input int unsigned lhr_w);
      return META_LIDX_LSB + lhr_w;
   endfunction

   function automatic int unsigned meta_ghr_lsb(input int unsigned lhr_w, input int unsigned idx_w);
      return META_LIDX_LSB + lhr_w + idx_w;
   endfunction

   function automatic sat_ctr_t sat_ctr_next(input sat_ctr_t ctr, input logic taken,
                                             input int unsigned ctr_w);
      sat_ctr_t max_val;
      max_val = sat_ctr_t'((1 << ctr_w) - 1);
      if (taken)
         return (ctr == max_val) ? ctr : ctr + sat_ctr_t'(1);
      else
         return (ctr == '0) ? ctr : ctr - sat_ctr_t'(1);
   endfunction

endpackage

// File: rtl/rv32i_types.sv
// Shared RV32I base types: machine word and major opcode encodings.
package rv32i_types;

   typedef logic [31:0] rv32i_word;

   typedef enum logic [6:0] {
      op_lui   = 7'b0110111,
      op_auipc = 7'b0010111,
      op_jal   = 7'b1101111,
      op_jalr  = 7'b1100111,
      op_br    = 7'b1100011,
      op_load  = 7'b0000011,
      op_store = 7'b0100011,
      op_imm   = 7'b0010011,
      op_reg   = 7'b0110011,
      op_csr   = 7'b1110011
   } rv32i_opcode;

endpackage

// File: rtl/sat_ctr_table.sv
// Table of saturating counters: combinational read, one synchronous
// read-modify-write port that steps the addressed counter toward wr_taken.
module sat_ctr_table
   import bp_pkg::*;
#(
   parameter int unsigned DEPTH_W   = 6,
   parameter int unsigned CTR_W     = 2,
   parameter int unsigned RESET_VAL = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [DEPTH_W-1:0] rd_idx,
   output logic [CTR_W-1:0]   rd_ctr,
   input  logic               wr_en,
   input  logic [DEPTH_W-1:0] wr_idx,
   input  logic               wr_taken
);

   localparam int unsigned DEPTH = 1 << DEPTH_W;

   logic [CTR_W-1:0] ctr_q [DEPTH];
   logic [CTR_W-1:0] wr_ctr_d;

   assign rd_ctr = ctr_q[rd_idx];

   always_comb begin
      wr_ctr_d = CTR_W'(sat_ctr_next(sat_ctr_t'(ctr_q[wr_idx]), wr_taken, CTR_W));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            ctr_q[i] <= CTR_W'(RESET_VAL);
         end
      end else if (wr_en) begin
         ctr_q[wr_idx] <= wr_ctr_d;
      end
   end

endmodule

// File: rtl/tournament_predictor.sv
// Tournament branch predictor (gshare + local history + per-PC chooser) with
// speculative global history. Define BP_PERF_CNT_EN to build the perf counters.
module tournament_predictor
   import rv32i_types::*;
   import bp_pkg::*;
#(
   parameter int unsigned IDX_W  = 6,
   parameter int unsigned GHR_W  = 6,
   parameter int unsigned LHR_W  = 4,
   parameter int unsigned CTR_W  = 2,
   parameter int unsigned META_W = GHR_W + IDX_W + LHR_W + 2
) (
   input  logic              clk,
   input  logic              rst,
   input  rv32i_word         pc,
   input  rv32i_opcode       op,
   input  rv32i_word         imm,
   input  logic              pred_valid,
   output logic              pred,
   output rv32i_word         pred_addr,
   output logic [META_W-1:0] pred_meta,
   input  logic              upd_valid,
   input  logic              upd_taken,
   input  logic              upd_mispred,
   input  rv32i_word         upd_pc,
   input  logic [META_W-1:0] upd_meta,
   output logic [31:0]       perf_total,
   output logic [31:0]       perf_mispred
);

   localparam int unsigned GIDX_LSB  = meta_gidx_lsb(LHR_W);
   localparam int unsigned GHR_LSB   = meta_ghr_lsb(LHR_W, IDX_W);
   localparam int unsigned LHT_DEPTH = 1 << IDX_W;
   localparam int unsigned CTR_WEAK  = 1 << (CTR_W - 1);

   logic [GHR_W-1:0] spec_ghr_q, spec_ghr_d;
   logic [LHR_W-1:0] lht_q [LHT_DEPTH];
   logic [LHR_W-1:0] lht_wr_d;

   logic [IDX_W-1:0] pc_idx, gidx, upd_pc_idx, upd_gidx;
   logic [LHR_W-1:0] lidx, upd_lidx;
   logic [GHR_W-1:0] upd_ghr_ckpt;
   logic             upd_gpred, upd_lpred;
   logic [CTR_W-1:0] g_ctr, l_ctr, cho_ctr;
   logic             gpred, lpred, is_br;

   // ---------------- prediction (combinational) ----------------
   assign pc_idx    = pc[IDX_W+1:2];
   assign gidx      = pc_idx ^ IDX_W'(spec_ghr_q);
   assign lidx      = lht_q[pc_idx];
   assign gpred     = g_ctr[CTR_W-1];
   assign lpred     = l_ctr[CTR_W-1];
   assign is_br     = (op == op_br);
   assign pred      = is_br & (cho_ctr[CTR_W-1] ? gpred : lpred);
   assign pred_addr = pc + imm;
   assign pred_meta = {spec_ghr_q, gidx, lidx, gpred, lpred};

   // ---------------- update metadata ----------------
   assign upd_pc_idx   = upd_pc[IDX_W+1:2];
   assign upd_lpred    = upd_meta[META_LPRED_BIT];
   assign upd_gpred    = upd_meta[META_GPRED_BIT];
   assign upd_lidx     = upd_meta[META_LIDX_LSB +: LHR_W];
   assign upd_gidx     = upd_meta[GIDX_LSB +: IDX_W];
   assign upd_ghr_ckpt = upd_meta[GHR_LSB +: GHR_W];

   sat_ctr_table #(.DEPTH_W(IDX_W), .CTR_W(CTR_W), .RESET_VAL(CTR_WEAK - 1)) u_gpht (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (gidx),
      .rd_ctr   (g_ctr),
      .wr_en    (upd_valid),
      .wr_idx   (upd_gidx),
      .wr_taken (upd_taken)
   );

   sat_ctr_table #(.DEPTH_W(LHR_W), .CTR_W(CTR_W), .RESET_VAL(CTR_WEAK - 1)) u_lpht (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (lidx),
      .rd_ctr   (l_ctr),
      .wr_en    (upd_valid),
      .wr_idx   (upd_lidx),
      .wr_taken (upd_taken)
   );

   // Chooser trains only when the components disagree; up means "trust gshare".
   sat_ctr_table #(.DEPTH_W(IDX_W), .CTR_W(CTR_W), .RESET_VAL(CTR_WEAK)) u_cho (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (pc_idx),
      .rd_ctr   (cho_ctr),
      .wr_en    (upd_valid & (upd_gpred != upd_lpred)),
      .wr_idx   (upd_pc_idx),
      .wr_taken (upd_gpred == upd_taken)
   );

   // ---------------- history state ----------------
   always_comb begin
      spec_ghr_d = spec_ghr_q;
      if (upd_valid && upd_mispred) begin
         spec_ghr_d = {upd_ghr_ckpt[GHR_W-2:0], upd_taken};
      end else if (pred_valid && is_br) begin
         spec_ghr_d = {spec_ghr_q[GHR_W-2:0], pred};
      end
   end

   always_comb begin
      lht_wr_d = {lht_q[upd_pc_idx][LHR_W-2:0], upd_taken};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         spec_ghr_q <= '0;
         for (int i = 0; i < LHT_DEPTH; i++) begin
            lht_q[i] <= '0;
         end
      end else begin
         spec_ghr_q <= spec_ghr_d;
         if (upd_valid) begin
            lht_q[upd_pc_idx] <= lht_wr_d;
         end
      end
   end

   // ---------------- performance counters ----------------
`ifdef BP_PERF_CNT_EN
   logic [31:0] perf_total_q, perf_total_d;
   logic [31:0] perf_mispred_q, perf_mispred_d;

   always_comb begin
      perf_total_d   = perf_total_q + 32'(upd_valid);
      perf_mispred_d = perf_mispred_q + 32'(upd_valid & upd_mispred);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_total_q   <= '0;
         perf_mispred_q <= '0;
      end else begin
         perf_total_q   <= perf_total_d;
         perf_mispred_q <= perf_mispred_d;
      end
   end

   assign perf_total   = perf_total_q;
   assign perf_mispred = perf_mispred_q;
`else
   assign perf_total   = '0;
   assign perf_mispred = '0;
`endif

   // PC alignment/high bits and the oldest checkpoint bit never index anything.
   logic unused_ok;
   assign unused_ok = ^{pc[31:IDX_W+2], pc[1:0], upd_pc[31:IDX_W+2], upd_pc[1:0],
                        upd_ghr_ckpt[GHR_W-1]};

endmodule

// File: doc/tournament_predictor.md
# tournament_predictor

Parametrised tournament branch direction predictor for the ID stage. It combines a gshare component (global history XOR PC), a local-history component (per-PC history feeding a local pattern table) and a per-PC chooser. The block speculatively updates global history at prediction time and restores it from a checkpoint on a mispredict. ID supplies the prediction request and consumes the prediction; EX returns resolution plus the metadata the block emitted at prediction time.

## Interface
Parameters:
- IDX_W, 6, index bits for the gshare PHT, local history table (LHT) and chooser; each table has 2**IDX_W entries.
- GHR_W, 6, global history length; must satisfy GHR_W ≤ IDX_W.
- LHR_W, 4, local history length; the local PHT has 2**LHR_W entries.
- CTR_W, 2, width of every saturating counter; CTR_W ≥ 2.
- META_W, GHR_W+IDX_W+LHR_W+2, derived metadata width; do not override.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- pc  in  32  rv32i_word; PC of the instruction in ID.
- op  in  rv32i_opcode  opcode of the instruction in ID.
- imm  in  32  branch immediate.
- pred_valid  in  1  the ID instruction advances this cycle.
- pred  out  1  predict taken; forced to 0 when op ≠ op_br.
- pred_addr  out  32  pc+imm, modulo 2^32.
- pred_meta  out  META_W  {ghr_ckpt, gidx, lidx, gpred, lpred}, MSB first.
- upd_valid  in  1  EX resolves a conditional branch this cycle.
- upd_taken  in  1  actual outcome.
- upd_mispred  in  1  EX redirect; asserted only when upd_valid=1.
- upd_pc  in  32  PC of the resolving branch.
- upd_meta  in  META_W  pred_meta carried with that branch.
- perf_total  out  32  resolved branches (see Configuration).
- perf_mispred  out  32  mispredicts (see Configuration).

## Operation
- Counters are saturating CTR_W-bit. "Taken" means the counter MSB is set. Increment saturates at all-ones; decrement saturates at 0.
- Prediction path is combinational from the current table state:
  - gidx = pc[IDX_W+1:2] ^ zero-extended spec_ghr; gpred = gpht[gidx].MSB.
  - lidx = lht[pc[IDX_W+1:2]]; lpred = lpht[lidx].MSB.
  - Chooser entry cho[pc[IDX_W+1:2]]: MSB=1 selects gpred, MSB=0 selects lpred.
  - ghr_ckpt = spec_ghr before any shift.
- When pred_valid & (op==op_br): spec_ghr <= {spec_ghr[GHR_W-2:0], pred}.
- When upd_valid, using fields unpacked from upd_meta:
  - gpht[gidx] moves toward upd_taken.
  - lpht[lidx] moves toward upd_taken.
  - lht[upd_pc[IDX_W+1:2]] <= {old[LHR_W-2:0], upd_taken}. Local history is non-speculative.
  - If gpred ≠ lpred, the chooser entry moves toward the correct component: increment if gpred==upd_taken, otherwise decrement. If gpred == lpred, the chooser is unchanged.
- When upd_valid & upd_mispred: spec_ghr <= {ghr_ckpt[GHR_W-2:0], upd_taken}. This overrides any same-cycle speculative shift.
- Simultaneous predict and update on the same entry: the prediction sees the pre-update value. The write lands at the clock edge.
- Reset values:
  - gpht and lpht: 2**(CTR_W-1)-1 (weakly not-taken).
  - cho: 2**(CTR_W-1) (weakly global).
  - lht: 0; spec_ghr: 0.
  - perf counters: 0.
  - pred reads 0 after reset.
- Reset asserted mid-operation discards all state and wins over same-cycle updates.

## Timing
- Prediction is zero-latency (combinational) in the request cycle.
- Updates and history shifts are visible to a prediction on the cycle after the update edge.
- There is no handshake or backpressure: the block accepts one prediction and one update per cycle.

## Configuration
- BP_PERF_CNT_EN defined:
  - perf_total increments on every upd_valid.
  - perf_mispred increments on every upd_valid & upd_mispred.
  - Both are 32-bit and wrap 0xFFFFFFFF→0.
- Not defined: both ports are tied to 0, no counter flops are synthesised, and the port list is unchanged.

## Structure
- rv32i_types supplies rv32i_word, rv32i_opcode and op_br.
- Add to a shared bp_pkg:
  - function sat_ctr_next(ctr, taken), parameterised through a CTR_W-wide type.
  - Meta field offset constants.
- Sub-module sat_ctr_table (params DEPTH_W, CTR_W, RESET_VAL): one combinational read port, one synchronous write port that performs the saturating step. It is instantiated three times (gpht, lpht, cho).

## Test plan
- Reset, then op=op_br, pc=0x100 → pred=0, pred_addr=0x100+imm, ghr_ckpt=0.
- Branch at pc=0x40 resolved taken twice with no mispredict flag and no speculative shifts → gpht[0x10] goes 1→2→3, next pred=1; with BP_PERF_CNT_EN, perf_total=2.
- Alternating T/N branch at one PC for 20 resolutions → local component wins: cho entry decrements to 0 and the last 8 predictions are correct.
- Three predicted-taken branches (spec_ghr=0b000111), then a mispredict on the first with ghr_ckpt=0, upd_taken=0 → spec_ghr=0 next cycle, even with a simultaneous pred_valid branch.
- pred_valid with a non-branch op → pred=0 and spec_ghr unchanged.
- Assert rst while upd_valid=1 → all tables return to their reset values, and the counters read 0 next cycle.
